ft245_sync_host_if: RTL and testbench

FT245_SYNC_HOST_IF -- requirements
Module: ft245_sync_host_if

---
 rtl/ft245_sync_host_if.sv | 259 +++++++++++++++++++++++++
 tb/tb_ft245_sync_host_if.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_sync_host_if.sv
// FT245 synchronous FIFO host interface.
// Inbound: hunts for 0xCD, assembles command/address (and data words for
// writes) and hands them to the downstream master one word at a time.
// Outbound: serialises response words (0xDC + status/address/data, then
// data-only words for multi-word responses) onto the shared FT245 bus.
//
// Handshakes: ih_ready is held high with stable in_* fields until the
// cycle in which master_ready is also high, which consumes the word.
// oh_en is only acted on in a cycle where oh_ready is high; oh_ready then
// stays low until the last byte of that word has been written.
module ft245_sync_host_if (
  input  logic        clk,
  input  logic        rst,
  input  logic        master_ready,
  output logic        ih_ready,
  output logic        ih_reset,
  output logic [31:0] in_command,
  output logic [31:0] in_address,
  output logic [31:0] in_data,
  output logic [27:0] in_data_count,
  output logic        oh_ready,
  input  logic        oh_en,
  input  logic [31:0] out_status,
  input  logic [31:0] out_address,
  input  logic [31:0] out_data,
  input  logic [27:0] out_data_count,
  input  logic        ftdi_clk,
  inout  wire  [7:0]  ftdi_data,
  input  logic        ftdi_txe_n,
  input  logic        ftdi_rde_n,
  output logic        ftdi_wr_n,
  output logic        ftdi_rd_n,
  output logic        ftdi_oe_n,
  output logic        ftdi_siwu,
  output logic [5:0]  dbg_state
);

  typedef enum logic [1:0] {R_IDLE, R_OE, R_RD} rd_state_t;
  typedef enum logic [1:0] {P_SYNC, P_CMD, P_ADDR, P_DATA} parse_state_t;
  typedef enum logic       {T_IDLE, T_SEND} tx_state_t;

  rd_state_t    rd_state, rd_next;
  parse_state_t p_state, p_next;
  tx_state_t    tx_state, tx_next;

  logic        alive;
  logic        word_pend;
  logic        capture;
  logic        word_done;
  logic        sync_err;
  logic [7:0]  rx_byte;
  logic [1:0]  byte_cnt;
  logic        byte_last;
  logic [31:0] shift_q;
  logic [31:0] shift_nx;
  logic [31:0] cmd_q;
  logic        is_write;
  logic [23:0] words_left;

  logic [31:0] st_q, ad_q, da_q;
  logic [3:0]  tx_idx;
  logic [27:0] tx_more;
  logic        tx_go;
  logic        tx_drive;
  logic        accept;
  logic [7:0]  tx_byte;

  logic        unused_ftdi_clk;
  assign unused_ftdi_clk = ftdi_clk;

  // ---------------------------------------------------------------------
  // Read side: a byte is taken in every cycle rd_n is low, which requires
  // RD state, data available and no word waiting for the master.
  // ---------------------------------------------------------------------
  assign rx_byte   = ftdi_data;
  assign capture   = (rd_state == R_RD) && !ftdi_rde_n && !word_pend;
  assign ftdi_rd_n = !capture;
  assign ftdi_oe_n = (rd_state == R_IDLE);
  assign byte_last = (byte_cnt == 2'd3);
  assign shift_nx  = {shift_q[23:0], rx_byte};
  assign is_write  = (cmd_q[31:24] == 8'h01);

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_state <= R_IDLE;
    else     rd_state <= rd_next;
  end

  // Read FSM next state; a pending read always wins over the transmitter.
  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      R_IDLE:  if (!ftdi_rde_n) rd_next = R_OE;
      R_OE:    rd_next = R_RD;
      R_RD:    if (ftdi_rde_n) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Packet parser state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) p_state <= P_SYNC;
    else     p_state <= p_next;
  end

  // Packet parser next state plus word-complete / framing-error flags.
  always_comb begin
    p_next    = p_state;
    word_done = 1'b0;
    sync_err  = 1'b0;
    if (capture) begin
      unique case (p_state)
        P_SYNC: begin
          if (rx_byte == 8'hCD) p_next = P_CMD;
          else                  sync_err = 1'b1;
        end
        P_CMD: if (byte_last) p_next = P_ADDR;
        P_ADDR: begin
          if (byte_last) begin
            if (is_write && (cmd_q[23:0] != 24'd0)) begin
              p_next = P_DATA;
            end else begin
              p_next    = P_SYNC;
              word_done = !is_write;
            end
          end
        end
        P_DATA: begin
          if (byte_last) begin
            word_done = 1'b1;
            if (words_left == 24'd1) p_next = P_SYNC;
          end
        end
        default: p_next = P_SYNC;
      endcase
    end
  end

  // Inbound datapath: byte assembly, decoded fields and the master handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ih_reset      <= 1'b0;
      word_pend     <= 1'b0;
      byte_cnt      <= 2'd0;
      shift_q       <= 32'd0;
      cmd_q         <= 32'd0;
      words_left    <= 24'd0;
      in_command    <= 32'd0;
      in_address    <= 32'd0;
      in_data       <= 32'd0;
      in_data_count <= 28'd0;
    end else begin
      ih_reset <= sync_err;
      if (capture) begin
        shift_q  <= shift_nx;
        byte_cnt <= (p_state == P_SYNC) ? 2'd0 : byte_cnt + 2'd1;
        if (p_state == P_CMD && byte_last) cmd_q <= shift_nx;
        if (p_state == P_ADDR && byte_last) begin
          in_command    <= cmd_q;
          in_address    <= shift_nx;
          in_data_count <= {4'h0, cmd_q[23:0]};
          words_left    <= cmd_q[23:0];
          if (!is_write) in_data <= 32'd0;
        end
        if (p_state == P_DATA && byte_last) begin
          in_data    <= shift_nx;
          words_left <= words_left - 24'd1;
        end
      end
      if (word_done)         word_pend <= 1'b1;
      else if (master_ready) word_pend <= 1'b0;
    end
  end

  assign ih_ready = word_pend;

  // ---------------------------------------------------------------------
  // Transmit side. tx_idx walks the 13-byte frame; data-only words of a
  // multi-word response start at index 9 (the data field).
  // ---------------------------------------------------------------------
  assign oh_ready  = alive && (tx_state == T_IDLE) && (rd_state == R_IDLE);
  assign accept    = oh_en && oh_ready;
  assign tx_go     = (tx_state == T_SEND) && !ftdi_txe_n && ftdi_rde_n &&
                     (rd_state == R_IDLE);
  assign tx_drive  = (tx_state == T_SEND) && (rd_state == R_IDLE);
  assign ftdi_wr_n = !tx_go;
  assign ftdi_data = tx_drive ? tx_byte : 8'bzzzz_zzzz;
  assign ftdi_siwu = 1'b1;

  // oh_ready stays low until the first clock after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) alive <= 1'b0;
    else     alive <= 1'b1;
  end

  // Transmit FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= T_IDLE;
    else     tx_state <= tx_next;
  end

  // Transmit FSM next state: leave SEND once the final byte is written.
  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      T_IDLE: if (accept) tx_next = T_SEND;
      T_SEND: if (tx_go && tx_idx == 4'd12) tx_next = T_IDLE;
      default: tx_next = T_IDLE;
    endcase
  end

  // Transmit datapath: latch fields on accept, advance on each written byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= 32'd0;
      ad_q    <= 32'd0;
      da_q    <= 32'd0;
      tx_idx  <= 4'd0;
      tx_more <= 28'd0;
    end else if (accept) begin
      st_q <= out_status;
      ad_q <= out_address;
      da_q <= out_data;
      if (tx_more == 28'd0) begin
        tx_idx  <= 4'd0;
        tx_more <= (out_data_count == 28'd0) ? 28'd0 : out_data_count - 28'd1;
      end else begin
        tx_idx  <= 4'd9;
        tx_more <= tx_more - 28'd1;
      end
    end else if (tx_go && tx_idx != 4'd12) begin
      tx_idx <= tx_idx + 4'd1;
    end
  end

  // Byte selection from the latched response frame, MSB first per field.
  always_comb begin
    tx_byte = 8'h00;
    unique case (tx_idx)
      4'd0:  tx_byte = 8'hDC;
      4'd1:  tx_byte = st_q[31:24];
      4'd2:  tx_byte = st_q[23:16];
      4'd3:  tx_byte = st_q[15:8];
      4'd4:  tx_byte = st_q[7:0];
      4'd5:  tx_byte = ad_q[31:24];
      4'd6:  tx_byte = ad_q[23:16];
      4'd7:  tx_byte = ad_q[15:8];
      4'd8:  tx_byte = ad_q[7:0];
      4'd9:  tx_byte = da_q[31:24];
      4'd10: tx_byte = da_q[23:16];
      4'd11: tx_byte = da_q[15:8];
      4'd12: tx_byte = da_q[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  assign dbg_state = {rd_state, p_state, tx_state, word_pend};

endmodule

// File: tb/tb_ft245_sync_host_if.sv
// Bench for ft245_sync_host_if: an FT245 pin model feeds byte queues,
// expected decoded words and transmit bytes come from a packet-level model.
module tb_ft245_sync_host_if;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        master_ready;
  logic        ih_ready, ih_reset;
  logic [31:0] in_command, in_address, in_data;
  logic [27:0] in_data_count;
  logic        oh_ready, oh_en;
  logic [31:0] out_status, out_address, out_data;
  logic [27:0] out_data_count;
  wire  [7:0]  ftdi_data;
  logic        ftdi_txe_n, ftdi_rde_n;
  logic        ftdi_wr_n, ftdi_rd_n, ftdi_oe_n, ftdi_siwu;
  logic [5:0]  dbg_state;
  logic [7:0]  host_byte;

  assign ftdi_data = (!ftdi_oe_n) ? host_byte : 8'bzzzz_zzzz;

  ft245_sync_host_if dut (
    .clk(clk), .rst(rst), .master_ready(master_ready),
    .ih_ready(ih_ready), .ih_reset(ih_reset),
    .in_command(in_command), .in_address(in_address), .in_data(in_data),
    .in_data_count(in_data_count),
    .oh_ready(oh_ready), .oh_en(oh_en),
    .out_status(out_status), .out_address(out_address), .out_data(out_data),
    .out_data_count(out_data_count),
    .ftdi_clk(clk), .ftdi_data(ftdi_data),
    .ftdi_txe_n(ftdi_txe_n), .ftdi_rde_n(ftdi_rde_n),
    .ftdi_wr_n(ftdi_wr_n), .ftdi_rd_n(ftdi_rd_n), .ftdi_oe_n(ftdi_oe_n),
    .ftdi_siwu(ftdi_siwu), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic        is_reset;
    logic [31:0] cmd;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t        exp_ev[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  int errors = 0;
  int checks = 0;

  logic rde_block = 1'b0, txe_block = 1'b0, mr_block = 1'b0, rnd_on = 1'b0;
  logic cap_pending = 1'b0, wr_pending = 1'b0;
  logic [7:0] wr_byte;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_rx32(input logic [31:0] v);
    for (int i = 3; i >= 0; i--) rx_q.push_back(v[8*i +: 8]);
  endtask

  task automatic push_tx32(input logic [31:0] v);
    for (int i = 3; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
  endtask

  // Write packets carry cmd[23:0] words base, base+1, ...
  task automatic push_packet(input logic [31:0] cmd, input logic [31:0] addr,
                             input logic [31:0] base);
    ev_t e;
    rx_q.push_back(8'hCD);
    push_rx32(cmd);
    push_rx32(addr);
    e.is_reset = 1'b0; e.cmd = cmd; e.addr = addr;
    if (cmd[31:24] == 8'h01) begin
      for (int i = 0; i < int'(cmd[23:0]); i++) begin
        push_rx32(base + i);
        e.data = base + i;
        exp_ev.push_back(e);
      end
    end else begin
      e.data = 32'd0;
      exp_ev.push_back(e);
    end
  endtask

  task automatic push_garbage(input logic [7:0] b);
    ev_t e;
    rx_q.push_back(b);
    e.is_reset = 1'b1; e.cmd = 0; e.addr = 0; e.data = 0;
    exp_ev.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_resp(input logic [31:0] st, input logic [31:0] ad,
                           input logic [31:0] da, input int cnt);
    exp_q.push_back(8'hDC);
    push_tx32(st);
    push_tx32(ad);
    push_tx32(da);
    for (int w = 1; w < cnt; w++) push_tx32(da + w);
    for (int w = 0; w < cnt; w++) begin
      int n = 0;
      @(negedge clk);
      while (!oh_ready && n < 3000) begin
        @(negedge clk);
        n++;
      end
      if (!oh_ready) begin
        check("oh_ready_timeout", {31'd0, oh_ready}, 32'd1);
        return;
      end
      out_status = st; out_address = ad; out_data = da + w;
      out_data_count = cnt[27:0];
      oh_en = 1'b1;
      @(negedge clk);
      oh_en = 1'b0;
      check("oh_ready_busy", {31'd0, oh_ready}, 32'd0);
    end
  endtask

  task automatic wait_rx_le(input int lim);
    int n = 0;
    while (rx_q.size() > lim && n < 2000) begin
      @(negedge clk);
      n++;
    end
    #2;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((rx_q.size() != 0 || exp_ev.size() != 0 || exp_q.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    check("drain", rx_q.size() + exp_ev.size() + exp_q.size(), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  // ---------------- FT245 pin model and monitors ----------------
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (cap_pending) begin
        if (rx_q.size() > 0) void'(rx_q.pop_front());
        cap_pending = 1'b0;
      end
      if (wr_pending) begin
        if (exp_q.size() == 0) check("tx_unexpected_byte", {24'd0, wr_byte}, 32'hFFFF_FFFF);
        else check("tx_byte", {24'd0, wr_byte}, {24'd0, exp_q.pop_front()});
        wr_pending = 1'b0;
      end
      ftdi_rde_n   = (rx_q.size() == 0) || rde_block || (rnd_on && $urandom_range(0, 5) == 0);
      host_byte    = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
      ftdi_txe_n   = txe_block || (rnd_on && $urandom_range(0, 4) == 0);
      master_ready = !(mr_block || (rnd_on && $urandom_range(0, 5) == 0));
      if (!rst) begin
        if (ih_reset) begin
          if (exp_ev.size() == 0) check("ih_reset_unexpected", {31'd0, ih_reset}, 32'd0);
          else begin
            e = exp_ev.pop_front();
            check("ih_reset_kind", {31'd0, e.is_reset}, 32'd1);
          end
        end
        if (ih_ready && master_ready) begin
          if (exp_ev.size() == 0) check("ih_ready_unexpected", {31'd0, ih_ready}, 32'd0);
          else begin
            e = exp_ev.pop_front();
            check("ih_ready_kind", {31'd0, e.is_reset}, 32'd0);
            check("in_command", in_command, e.cmd);
            check("in_address", in_address, e.addr);
            check("in_data", in_data, e.data);
            check("in_data_count", {4'h0, in_data_count}, {8'h0, e.cmd[23:0]});
          end
        end
      end
      #1;
      if (ih_ready && !master_ready) check("rd_n_during_stall", {31'd0, ftdi_rd_n}, 32'd1);
      if (!ftdi_oe_n) check("wr_n_while_oe", {31'd0, ftdi_wr_n}, 32'd1);
      if (!ftdi_wr_n) check("wr_needs_txe", {31'd0, ftdi_txe_n}, 32'd0);
      cap_pending = !ftdi_rd_n && !ftdi_rde_n;
      wr_pending  = !ftdi_wr_n && !ftdi_txe_n;
      wr_byte     = ftdi_data;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] cmd, addr, base;
    oh_en = 1'b0; out_status = 0; out_address = 0; out_data = 0; out_data_count = 0;
    master_ready = 1'b1; ftdi_rde_n = 1'b1; ftdi_txe_n = 1'b0; host_byte = 8'h00;

    repeat (3) @(negedge clk);
    #2;
    check("rst_rd_n", {31'd0, ftdi_rd_n}, 32'd1);
    check("rst_oe_n", {31'd0, ftdi_oe_n}, 32'd1);
    check("rst_wr_n", {31'd0, ftdi_wr_n}, 32'd1);
    check("rst_siwu", {31'd0, ftdi_siwu}, 32'd1);
    check("rst_ih_ready", {31'd0, ih_ready}, 32'd0);
    check("rst_ih_reset", {31'd0, ih_reset}, 32'd0);
    check("rst_oh_ready", {31'd0, oh_ready}, 32'd0);
    check("rst_in_command", in_command, 32'd0);
    check("rst_in_address", in_address, 32'd0);
    check("rst_in_data", in_data, 32'd0);
    check("rst_in_count", {4'h0, in_data_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #2;
    check("oh_ready_after_rst", {31'd0, oh_ready}, 32'd1);

    // Ping, write burst, read.
    push_packet(32'h0000_0000, 32'h0000_0000, 32'd0);
    wait_idle(500);
    push_packet(32'h0100_0002, 32'h0000_0100, 32'd1);
    wait_idle(500);
    push_packet(32'h0200_0001, 32'h0100_0000, 32'd0);
    wait_idle(500);

    // Bad sync byte then a normal ping.
    push_garbage(8'hAB);
    push_packet(32'h0000_0000, 32'h0000_0000, 32'd0);
    wait_idle(500);

    // Long rde_n gap in the middle of a write packet.
    push_packet(32'h0100_0003, 32'h0000_2000, 32'hA000_0000);
    wait_rx_le(8);
    rde_block = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    check("gap_rd_n", {31'd0, ftdi_rd_n}, 32'd1);
    check("gap_oe_n", {31'd0, ftdi_oe_n}, 32'd1);
    repeat (31) @(negedge clk);
    rde_block = 1'b0;
    wait_idle(500);

    // Master back-pressure for 10 cycles.
    push_packet(32'h0100_0003, 32'h0000_3000, 32'hB000_0000);
    wait_rx_le(10);
    mr_block = 1'b1;
    repeat (10) @(negedge clk);
    mr_block = 1'b0;
    wait_idle(500);

    // Single-word response with a 3-cycle txe_n stall mid-stream.
    fork
      send_resp(32'hFFFF_FFFF, 32'h0100_0000, 32'h0123_4567, 1);
      begin
        int n = 0;
        while (exp_q.size() > 7 && n < 500) begin
          @(negedge clk);
          n++;
        end
        #2;
        txe_block = 1'b1;
        repeat (3) @(negedge clk);
        txe_block = 1'b0;
      end
    join
    wait_idle(500);
    check("oh_ready_idle", {31'd0, oh_ready}, 32'd1);

    // Three-word response.
    send_resp(32'h0000_0001, 32'h0000_0040, 32'h1111_0000, 3);
    wait_idle(500);

    // Reset in the middle of an inbound write, then a clean ping.
    push_packet(32'h0100_0002, 32'h0000_5000, 32'hC000_0000);
    wait_rx_le(8);
    rst = 1'b1;
    rx_q.delete();
    exp_ev.delete();
    cap_pending = 1'b0;
    wr_pending  = 1'b0;
    #1;
    check("midrst_rd_n", {31'd0, ftdi_rd_n}, 32'd1);
    check("midrst_oe_n", {31'd0, ftdi_oe_n}, 32'd1);
    check("midrst_ih_ready", {31'd0, ih_ready}, 32'd0);
    check("midrst_oh_ready", {31'd0, oh_ready}, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    #2;
    check("oh_ready_after_midrst", {31'd0, oh_ready}, 32'd1);
    push_packet(32'h0000_0000, 32'h0000_0000, 32'd0);
    wait_idle(500);

    // Randomised traffic with noise on rde_n, txe_n and master_ready.
    rnd_on = 1'b1;
    for (int it = 0; it < 25; it++) begin
      fork
        begin
          for (int p = 0; p < 3; p++) begin
            logic [7:0] g;
            if ($urandom_range(0, 4) == 0) begin
              g = 8'($urandom_range(0, 255));
              if (g == 8'hCD) g = 8'h00;
              push_garbage(g);
            end
            addr = $urandom;
            base = $urandom;
            case ($urandom_range(0, 2))
              0: cmd = {8'h01, 24'($urandom_range(1, 3))};
              1: cmd = {8'h02, 24'($urandom)};
              default: begin
                cmd = $urandom;
                if (cmd[31:24] == 8'h01) cmd[31:24] = 8'h7F;
              end
            endcase
            push_packet(cmd, addr, base);
          end
        end
        begin
          if ($urandom_range(0, 1) == 1)
            send_resp($urandom, $urandom, $urandom, $urandom_range(1, 3));
        end
      join
      wait_idle(3000);
    end
    rnd_on = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
